// File: rtl/vdma_axi4s_to_video_out.sv
// Raster video output stage fed by the VDMA pixel stream: runs free video timing, pulls pixels
// only during active video and relocks to the frame-start beat after any stream error.
module vdma_axi4s_to_video_out #(
    parameter int   DATA_WIDTH = 24,
    parameter int   USER_WIDTH = 1,
    parameter int   H_WIDTH    = 12,
    parameter int   V_WIDTH    = 12,
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FPORCH   = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BPORCH   = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FPORCH   = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BPORCH   = 33,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  ctl_enable,
    output logic                  ctl_busy,
    output logic                  stat_underflow,
    input  logic [USER_WIDTH-1:0] s_axi4s_tuser,
    input  logic                  s_axi4s_tlast,
    input  logic [DATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                  s_axi4s_tvalid,
    output logic                  s_axi4s_tready,
    output logic                  out_vsync,
    output logic                  out_hsync,
    output logic                  out_de,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int H_TOTAL = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

    localparam logic [H_WIDTH-1:0] H_LAST     = H_WIDTH'(H_TOTAL - 1);
    localparam logic [H_WIDTH-1:0] H_VIS      = H_WIDTH'(H_VISIBLE);
    localparam logic [H_WIDTH-1:0] H_VIS_LAST = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [H_WIDTH-1:0] H_SS       = H_WIDTH'(H_VISIBLE + H_FPORCH);
    localparam logic [H_WIDTH-1:0] H_SE       = H_WIDTH'(H_VISIBLE + H_FPORCH + H_SYNC);
    localparam logic [H_WIDTH-1:0] H_ONE      = H_WIDTH'(1);
    localparam logic [V_WIDTH-1:0] V_LAST     = V_WIDTH'(V_TOTAL - 1);
    localparam logic [V_WIDTH-1:0] V_VIS      = V_WIDTH'(V_VISIBLE);
    localparam logic [V_WIDTH-1:0] V_SS       = V_WIDTH'(V_VISIBLE + V_FPORCH);
    localparam logic [V_WIDTH-1:0] V_SE       = V_WIDTH'(V_VISIBLE + V_FPORCH + V_SYNC);
    localparam logic [V_WIDTH-1:0] V_ONE      = V_WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [H_WIDTH-1:0]    h_q, h_d;
    logic [V_WIDTH-1:0]    v_q, v_d;
    logic                  stop_q, stop_d;
    logic                  underflow_q, underflow_d;
    logic                  de_q, de_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic tready;
    logic de_now;
    logic at_origin;
    logic at_end;
    logic line_end;
    logic hsync_act;
    logic vsync_act;
    logic stop_next;
    logic tuser0;

    assign tuser0 = s_axi4s_tuser[0];

    // Raster position decode from the current counter values.
    always_comb begin
        de_now    = (h_q < H_VIS) && (v_q < V_VIS);
        at_origin = (h_q == '0) && (v_q == '0);
        at_end    = (h_q == H_LAST) && (v_q == V_LAST);
        line_end  = (h_q == H_VIS_LAST);
        hsync_act = (h_q >= H_SS) && (h_q < H_SE);
        vsync_act = (v_q >= V_SS) && (v_q < V_SE);
    end

    // Next-state: stream lock FSM, timing counters and the registered video outputs.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        stop_d      = stop_q;
        underflow_d = underflow_q;
        de_d        = 1'b0;
        hsync_d     = ~HSYNC_POL;
        vsync_d     = ~VSYNC_POL;
        data_d      = '0;
        tready      = 1'b0;
        stop_next   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                h_d    = '0;
                v_d    = '0;
                stop_d = 1'b0;
                if (ctl_enable) begin
                    state_d     = ST_SYNC;
                    underflow_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                // Non-frame-start beats are flushed; the frame-start beat waits for the origin.
                tready = at_origin | ~tuser0;
                if (at_origin && s_axi4s_tvalid && tuser0) begin
                    state_d = ST_RUN;
                    data_d  = s_axi4s_tdata;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_RUN: begin
                tready = de_now;
                if (de_now) begin
                    if (!s_axi4s_tvalid) begin
                        underflow_d = 1'b1;
                        state_d     = ST_SYNC;
                    end else if ((s_axi4s_tlast != line_end) || (tuser0 != at_origin)) begin
                        underflow_d = 1'b1;
                        state_d     = ST_SYNC;
                    end else begin
                        data_d = s_axi4s_tdata;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            de_d      = de_now;
            hsync_d   = hsync_act ? HSYNC_POL : ~HSYNC_POL;
            vsync_d   = vsync_act ? VSYNC_POL : ~VSYNC_POL;
            stop_next = stop_q | ~ctl_enable;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : (v_q + V_ONE);
            end else begin
                h_d = h_q + H_ONE;
            end
            // A disable request is latched and honoured only on the final cycle of the frame.
            if (at_end && stop_next) begin
                state_d = ST_IDLE;
                stop_d  = 1'b0;
            end else begin
                stop_d = stop_next;
            end
        end else begin
            de_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            stop_q      <= 1'b0;
            underflow_q <= 1'b0;
            de_q        <= 1'b0;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            stop_q      <= stop_d;
            underflow_q <= underflow_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            data_q      <= data_d;
        end
    end

    assign ctl_busy       = (state_q != ST_IDLE);
    assign stat_underflow = underflow_q;
    assign s_axi4s_tready = tready;
    assign out_de         = de_q;
    assign out_hsync      = hsync_q;
    assign out_vsync      = vsync_q;
    assign out_data       = data_q;

endmodule

// File: tb/tb_vdma_axi4s_to_video_out.sv
// Scoreboard bench: a frame-position reference model predicts each cycle's registered outputs,
// a monitor compares them one cycle later; random pixel data, junk beats, drops and errors.
module tb_vdma_axi4s_to_video_out;

    localparam int DW = 24;
    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ctl_enable;
    logic          ctl_busy;
    logic          stat_underflow;
    logic [0:0]    s_axi4s_tuser;
    logic          s_axi4s_tlast;
    logic [DW-1:0] s_axi4s_tdata;
    logic          s_axi4s_tvalid;
    logic          s_axi4s_tready;
    logic          out_vsync;
    logic          out_hsync;
    logic          out_de;
    logic [DW-1:0] out_data;

    always #5 aclk = ~aclk;

    vdma_axi4s_to_video_out #(
        .DATA_WIDTH(DW), .USER_WIDTH(1), .H_WIDTH(12), .V_WIDTH(12),
        .H_VISIBLE(HV), .H_FPORCH(HF), .H_SYNC(HS), .H_BPORCH(HB),
        .V_VISIBLE(VV), .V_FPORCH(VF), .V_SYNC(VS), .V_BPORCH(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .aclk(aclk), .areset(areset), .ctl_enable(ctl_enable), .ctl_busy(ctl_busy),
        .stat_underflow(stat_underflow), .s_axi4s_tuser(s_axi4s_tuser),
        .s_axi4s_tlast(s_axi4s_tlast), .s_axi4s_tdata(s_axi4s_tdata),
        .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de), .out_data(out_data)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    typedef struct {
        logic          de;
        logic          hs;
        logic          vs;
        logic [DW-1:0] data;
        logic          uf;
        logic          busy;
    } exp_t;

    beat_t src_q[$];
    exp_t  sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: 0 idle, 1 hunting for frame start, 2 locked; position within the frame.
    int m_state = 0;
    int m_pos   = 0;
    bit m_stop  = 1'b0;
    bit m_uf    = 1'b0;

    bit en_req  = 1'b0;
    bit hs_prev = 1'b0;
    int cyc     = 0;
    int drop_at = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered output is compared against the prediction made for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_de",         32'(out_de),         32'(e.de));
                check("out_hsync",      32'(out_hsync),      32'(e.hs));
                check("out_vsync",      32'(out_vsync),      32'(e.vs));
                check("out_data",       32'(out_data),       32'(e.data));
                check("stat_underflow", 32'(stat_underflow), 32'(e.uf));
                check("ctl_busy",       32'(ctl_busy),       32'(e.busy));
            end
        end
    end

    task automatic cycle();
        beat_t b;
        exp_t  e;
        bit    tv, mt, de;
        int    h, v, st0;
        @(negedge aclk);
        if (hs_prev && src_q.size() > 0) b = src_q.pop_front();
        b  = '{data: '0, user: 1'b0, last: 1'b0};
        if (src_q.size() > 0) b = src_q[0];
        tv = (src_q.size() > 0) && (cyc != drop_at);
        ctl_enable     = en_req;
        s_axi4s_tvalid = tv;
        s_axi4s_tdata  = b.data;
        s_axi4s_tuser  = b.user;
        s_axi4s_tlast  = b.last;
        #1;
        h   = m_pos % HT;
        v   = m_pos / HT;
        st0 = m_state;
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.data = '0;
        mt  = 1'b0;
        if (m_state == 0) begin
            if (en_req) begin
                m_state = 1; m_uf = 1'b0; m_pos = 0; m_stop = 1'b0;
            end
        end else begin
            de   = (h < HV) && (v < VV);
            e.de = de;
            e.hs = !((h >= HV + HF) && (h < HV + HF + HS));
            e.vs = !((v >= VV + VF) && (v < VV + VF + VS));
            if (m_state == 1) begin
                mt = (m_pos == 0) || !b.user;
                if (m_pos == 0 && tv && b.user) begin
                    m_state = 2;
                    e.data  = b.data;
                end
            end else begin
                mt = de;
                if (de) begin
                    if (!tv || (b.last != (h == HV - 1)) || (b.user != (m_pos == 0))) begin
                        m_uf = 1'b1; m_state = 1;
                    end else begin
                        e.data = b.data;
                    end
                end
            end
            m_stop = m_stop || !en_req;
            if (m_pos == FT - 1 && m_stop) begin
                m_state = 0; m_stop = 1'b0; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FT;
            end
        end
        e.uf   = m_uf;
        e.busy = (m_state != 0);
        if (tv || st0 != 1) check("s_axi4s_tready", 32'(s_axi4s_tready), 32'(mt));
        hs_prev = tv && s_axi4s_tready;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic push_frame(input int bad_last_idx);
        for (int i = 0; i < HV * VV; i++) begin
            beat_t b;
            b.data = 24'($urandom());
            b.user = (i == 0);
            b.last = ((i % HV) == HV - 1) || (i == bad_last_idx);
            src_q.push_back(b);
        end
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = 24'($urandom());
            b.user = 1'b0;
            b.last = 1'($urandom_range(0, 1));
            src_q.push_back(b);
        end
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        areset = 1'b1;
        s_axi4s_tvalid = 1'b0;
        ctl_enable = 1'b0;
        #1;
        check("rst_busy",   32'(ctl_busy),       32'(0));
        check("rst_uf",     32'(stat_underflow), 32'(0));
        check("rst_tready", 32'(s_axi4s_tready), 32'(0));
        check("rst_de",     32'(out_de),         32'(0));
        check("rst_data",   32'(out_data),       32'(0));
        check("rst_hsync",  32'(out_hsync),      32'(1));
        check("rst_vsync",  32'(out_vsync),      32'(1));
        sb_q.delete();
        m_state = 0; m_pos = 0; m_stop = 1'b0; m_uf = 1'b0;
        hs_prev = 1'b0; en_req = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        en_req = 1'b0;
        while (ctl_busy && n < 120) begin
            cycle();
            n++;
        end
        check("idle_reached", 32'(ctl_busy), 32'(0));
        cycle();
        cycle();
        check("idle_tready", 32'(s_axi4s_tready), 32'(0));
        check("idle_hsync",  32'(out_hsync),      32'(1));
        check("idle_vsync",  32'(out_vsync),      32'(1));
        check("idle_de",     32'(out_de),         32'(0));
    endtask

    task automatic play(input int frames);
        en_req = 1'b1;
        cyc = 0;
        repeat (FT * frames - 10) cycle();
        wait_idle();
        src_q.delete();
        drop_at = -1;
    endtask

    initial begin
        areset = 1'b1; ctl_enable = 1'b0;
        s_axi4s_tvalid = 1'b0; s_axi4s_tdata = '0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0;
        apply_reset();
        repeat (3) cycle();

        // Clean streaming of three frames.
        push_frame(-1); push_frame(-1); push_frame(-1);
        play(3);
        check("t1_uf_clear", 32'(stat_underflow), 32'(0));

        // Junk ahead of the first frame start.
        push_junk(5); push_frame(-1); push_frame(-1);
        play(3);
        check("t2_uf_clear", 32'(stat_underflow), 32'(0));

        // Missing beat at pixel h=2, v=1.
        push_frame(-1); push_frame(-1);
        drop_at = 1 + 1 * HT + 2;
        play(2);
        check("t3_uf_set", 32'(stat_underflow), 32'(1));

        // Early tlast on the third beat of line 1.
        push_frame(HV + 2); push_frame(-1);
        play(2);
        check("t4_uf_set", 32'(stat_underflow), 32'(1));

        // Disable mid-frame, brief re-enable has no effect.
        push_frame(-1); push_frame(-1);
        en_req = 1'b1; cyc = 0;
        repeat (21) cycle();
        en_req = 1'b0;
        repeat (10) cycle();
        en_req = 1'b1;
        repeat (5) cycle();
        check("t5_still_busy", 32'(ctl_busy), 32'(1));
        wait_idle();
        src_q.delete();
        check("t5_uf_clear", 32'(stat_underflow), 32'(0));

        // Reset at pixel (1,1), then relock.
        push_frame(-1); push_frame(-1);
        en_req = 1'b1; cyc = 0;
        repeat (10) cycle();
        apply_reset();
        play(2);
        check("t6_uf_clear", 32'(stat_underflow), 32'(0));

        repeat (2) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
